fire_scheduler: RTL and testbench
=================================

Name: fire_scheduler

Overview:
- Generates the `fire` index that drives the per-signal capture-DFF enables (ENA = fire == idx) of the generated synchronous circuit model.
- Replaces the free `fire` register with a deterministic, fair, round-robin scheduler, so the model can run in plain simulation and emulation without a model checker choosing `fire`.
- Sits directly upstream of the circuit block; consumes per-signal excitation flags computed from the circuit (precap != current value).

Parameters:
- NSIG, 8, number of schedulable signals (inputs plus stateful outputs/internals); firing indices are 0..NSIG-1.
- FIREBITS, 4, width of `fire`; NSIG < 2**FIREBITS is required so the all-ones code is a guaranteed no-fire value.
- QUIET_CYCLES, 4, consecutive empty SELECT cycles before `quiescent` asserts; range 1..255.
- CNTW, 16, width of the fire event counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scheduler run permission; when low, no new fire is issued.
- excited  input  NSIG  bit i high = signal i is excited (its precap differs from its captured value).
- fire  output  FIREBITS  index of the signal enabled this cycle; all-ones = none.
- fire_valid  output  1  high when `fire` carries a real index.
- quiescent  output  1  no excited signal seen for QUIET_CYCLES consecutive SELECT cycles.
- fire_count  output  CNTW  total number of fire events since reset; wraps modulo 2**CNTW.

Behaviour:
- Reset (reset = 0, async):
  - state = SELECT, fire = all-ones, fire_valid = 0.
  - quiescent = 0, fire_count = 0, quiet counter = 0, pointer = NSIG-1, so index 0 has first priority.
- The FSM has two states, SELECT and FIRE; all outputs are registered.
- SELECT:
  - If enable = 1 and excited != 0:
    - choose the first excited index scanning ptr+1, ptr+2, ... modulo NSIG;
    - register fire = choice, fire_valid = 1, ptr = choice, quiet counter = 0, quiescent = 0;
    - go to FIRE.
  - If enable = 1 and excited == 0:
    - quiet counter increments, saturating at QUIET_CYCLES;
    - quiescent = 1 once the counter equals QUIET_CYCLES;
    - stay in SELECT with fire = all-ones.
  - If enable = 0: hold ptr, the quiet counter and quiescent; stay in SELECT with fire = all-ones.
- FIRE:
  - fire is held for exactly one cycle; the target DFF captures at the edge that ends this cycle.
  - At that edge: fire = all-ones, fire_valid = 0, fire_count += 1, return to SELECT.
  - `enable` is ignored in FIRE; an issued fire always completes.
- Cadence: at most one fire every 2 cycles. The SELECT cycle lets `excited` settle after the previous capture, so selection never uses stale excitation.
- Latency: an excited flag that is high in a SELECT cycle yields fire_valid in the next cycle.
- Fairness: a continuously excited signal fires within NSIG fire events.
- Boundaries:
  - Only one excited signal: it is chosen even when it equals ptr (the scan wraps fully).
  - excited bits at index >= NSIG do not exist; `fire` never takes a value >= NSIG except all-ones.
  - excited changing while in FIRE has no effect until the next SELECT.
  - fire_count wraps from 2**CNTW-1 to 0 with no flag.
  - Reset asserted mid-FIRE forces fire = all-ones asynchronously, so no capture occurs at the following edge.

Optional Feature:
- Macro: FIRE_SCHED_LFSR_EN.
- Defined:
  - a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every SELECT cycle;
  - the scan start becomes LFSR[FIREBITS-1:0] modulo NSIG instead of ptr+1;
  - this gives randomized interleavings for simulation coverage; fairness is not guaranteed.
- Undefined: pure round-robin as above; no LFSR logic is present.

Decomposition:
- Package fire_sched_pkg:
  - state enum {SELECT, FIRE};
  - function returning the no-fire code ('1 of width FIREBITS);
  - LFSR seed and tap constants.
- Sub-module rr_pick:
  - combinational rotating priority encoder;
  - inputs: NSIG request vector and start index;
  - outputs: chosen index and found flag.

Test Plan:
- Reset release with excited = 8'h00, enable = 1 -> fire = 4'hF throughout; quiescent rises on the 4th SELECT cycle; fire_count = 0.
- excited = 8'h01 held, enable = 1 -> fire = 0, fire_valid = 1 on alternate cycles; fire_count = 5 after 10 cycles.
- excited = 8'hFF held -> fire sequence 0,1,2,...,7,0 with a 4'hF cycle between each; each index appears once per 16 cycles.
- excited = 8'h24 with ptr = 2 -> next fire = 5, then 2; excited drops to 8'h00 -> fire stays 4'hF, quiescent after 4 cycles, cleared on the next fire.
- enable = 0 while excited = 8'h10 -> no fire and ptr held; enable = 1 -> fire = 4 in the next cycle.
- reset asserted during a FIRE cycle with fire = 3 -> fire = 4'hF and fire_valid = 0 immediately (asynchronous); fire_count = 0.

Source files
------------

// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the fire scheduler: FSM state, no-fire code helper,
// and LFSR constants used only when FIRE_SCHED_LFSR_EN is defined.
package fire_sched_pkg;

    typedef enum logic {SELECT, FIRE} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int no_fire_code(input int fb);
        return (1 << fb) - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request at or after i_start,
// wrapping modulo NSIG, so a lone request is found wherever the scan begins.
module rr_pick
    import fire_sched_pkg::*;
#(
    parameter int NSIG     = 8,
    parameter int FIREBITS = 4
) (
    input  logic [NSIG-1:0]     i_req,
    input  logic [FIREBITS-1:0] i_start,
    output logic [FIREBITS-1:0] o_idx,
    output logic                o_found
);

    always_comb begin
        int j;
        o_idx   = '0;
        o_found = 1'b0;
        j       = 0;
        for (int k = 0; k < NSIG; k++) begin
            j = (int'(i_start) + k) % NSIG;
            if (!o_found && i_req[j]) begin
                o_found = 1'b1;
                o_idx   = FIREBITS'(j);
            end
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Round-robin scheduler producing the capture-enable index `fire` for the circuit model.
// Define FIRE_SCHED_LFSR_EN to start each scan at a pseudo-random index instead of ptr+1.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int NSIG         = 8,
    parameter int FIREBITS     = 4,
    parameter int QUIET_CYCLES = 4,
    parameter int CNTW         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NSIG-1:0]     excited,
    output logic [FIREBITS-1:0] fire,
    output logic                fire_valid,
    output logic                quiescent,
    output logic [CNTW-1:0]     fire_count
);

    localparam logic [FIREBITS-1:0] NOFIRE = FIREBITS'(no_fire_code(FIREBITS));
    localparam logic [7:0]          QMAX   = 8'(QUIET_CYCLES);

    state_t              r_state, w_nxt_state;
    logic [FIREBITS-1:0] r_fire, w_nxt_fire;
    logic                r_valid, w_nxt_valid;
    logic                r_quiet, w_nxt_quiet;
    logic [CNTW-1:0]     r_count, w_nxt_count;
    logic [7:0]          r_qcnt, w_nxt_qcnt;
    logic [FIREBITS-1:0] r_ptr, w_nxt_ptr;
    logic [FIREBITS-1:0] w_start;
    logic [FIREBITS-1:0] w_pick;
    logic                w_found;

`ifdef FIRE_SCHED_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == SELECT) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign w_start = FIREBITS'(int'(r_lfsr[FIREBITS-1:0]) % NSIG);
`else
    assign w_start = (r_ptr == FIREBITS'(NSIG - 1)) ? '0 : r_ptr + FIREBITS'(1);
`endif

    rr_pick #(
        .NSIG     (NSIG),
        .FIREBITS (FIREBITS)
    ) u_pick (
        .i_req   (excited),
        .i_start (w_start),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SELECT;
            r_fire  <= NOFIRE;
            r_valid <= 1'b0;
            r_quiet <= 1'b0;
            r_count <= '0;
            r_qcnt  <= '0;
            r_ptr   <= FIREBITS'(NSIG - 1);
        end else begin
            r_state <= w_nxt_state;
            r_fire  <= w_nxt_fire;
            r_valid <= w_nxt_valid;
            r_quiet <= w_nxt_quiet;
            r_count <= w_nxt_count;
            r_qcnt  <= w_nxt_qcnt;
            r_ptr   <= w_nxt_ptr;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_fire  = NOFIRE;
        w_nxt_valid = 1'b0;
        w_nxt_quiet = r_quiet;
        w_nxt_count = r_count;
        w_nxt_qcnt  = r_qcnt;
        w_nxt_ptr   = r_ptr;
        case (r_state)
            SELECT: begin
                if (enable) begin
                    if (w_found) begin
                        w_nxt_fire  = w_pick;
                        w_nxt_valid = 1'b1;
                        w_nxt_ptr   = w_pick;
                        w_nxt_qcnt  = '0;
                        w_nxt_quiet = 1'b0;
                        w_nxt_state = FIRE;
                    end else begin
                        if (r_qcnt < QMAX) begin
                            w_nxt_qcnt = r_qcnt + 8'd1;
                        end
                        w_nxt_quiet = (w_nxt_qcnt == QMAX);
                    end
                end
            end
            FIRE: begin
                // The issued index has been held for its one capture cycle; retire it.
                w_nxt_count = r_count + CNTW'(1);
                w_nxt_state = SELECT;
            end
            default: w_nxt_state = SELECT;
        endcase
    end

    assign fire       = r_fire;
    assign fire_valid = r_valid;
    assign quiescent  = r_quiet;
    assign fire_count = r_count;

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler with hand-computed expected fire sequences.
module tb_fire_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] excited;
    logic [3:0] fire;
    logic       fire_valid;
    logic       quiescent;
    logic [15:0] fire_count;

    int n_checks = 0;
    int n_fail   = 0;

    fire_scheduler #(
        .NSIG         (8),
        .FIREBITS     (4),
        .QUIET_CYCLES (4),
        .CNTW         (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .excited    (excited),
        .fire       (fire),
        .fire_valid (fire_valid),
        .quiescent  (quiescent),
        .fire_count (fire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        excited = 8'h00;
        #22;
        check_eq("rst_fire", 32'(fire), 32'hF);
        check_eq("rst_valid", 32'(fire_valid), 0);
        check_eq("rst_quiet", 32'(quiescent), 0);
        check_eq("rst_count", 32'(fire_count), 0);

        // Idle after reset: quiescent rises on the 4th empty SELECT cycle
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("idle_fire", 32'(fire), 32'hF);
            check_eq("idle_quiet", 32'(quiescent), (i == 4) ? 1 : 0);
        end
        check_eq("idle_count", 32'(fire_count), 0);

        // Single excited signal 0: fires on alternate cycles, ptr starts at 7
        excited = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("one_fire", 32'(fire), (i % 2 == 1) ? 0 : 32'hF);
            check_eq("one_valid", 32'(fire_valid), (i % 2 == 1) ? 1 : 0);
            if (i == 1) check_eq("one_quiet_clr", 32'(quiescent), 0);
        end
        check_eq("one_count", 32'(fire_count), 5);

        // All excited with ptr = 0: expect 1,2,...,7,0 separated by no-fire cycles
        excited = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("all_fire", 32'(fire), (i % 2 == 0) ? ((i / 2 + 1) % 8) : 32'hF);
        end
        check_eq("all_count", 32'(fire_count), 13);

        // Bring ptr to 2, then excited = 0x24 -> 5 then 2
        excited = 8'h04;
        tick(); check_eq("p2_fire", 32'(fire), 2);
        tick(); check_eq("p2_gap", 32'(fire), 32'hF);
        excited = 8'h24;
        tick(); check_eq("x24_fire_a", 32'(fire), 5);
        tick(); check_eq("x24_gap", 32'(fire), 32'hF);
        tick(); check_eq("x24_fire_b", 32'(fire), 2);
        tick(); check_eq("x24_count", 32'(fire_count), 16);

        excited = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("q2_fire", 32'(fire), 32'hF);
            check_eq("q2_quiet", 32'(quiescent), (i == 4) ? 1 : 0);
        end

        // Disabled: no fire, ptr and quiescent held
        enable  = 1'b0;
        excited = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dis_fire", 32'(fire), 32'hF);
            check_eq("dis_quiet", 32'(quiescent), 1);
        end
        enable = 1'b1;
        tick();
        check_eq("en_fire", 32'(fire), 4);
        check_eq("en_valid", 32'(fire_valid), 1);
        check_eq("en_quiet", 32'(quiescent), 0);
        tick();
        check_eq("en_count", 32'(fire_count), 17);

        // Excitation dropping during FIRE does not cancel the issued fire
        excited = 8'h08;
        tick(); check_eq("mid_fire", 32'(fire), 3);
        excited = 8'h00;
        tick();
        check_eq("mid_done", 32'(fire), 32'hF);
        check_eq("mid_count", 32'(fire_count), 18);

        // Lone request equal to ptr (3) is still found; then async reset mid-FIRE
        excited = 8'h08;
        tick(); check_eq("self_fire", 32'(fire), 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_fire", 32'(fire), 32'hF);
        check_eq("arst_valid", 32'(fire_valid), 0);
        check_eq("arst_count", 32'(fire_count), 0);

        // After reset release, ptr is back to 7 so index 0 has first priority
        tick();
        reset   = 1'b1;
        excited = 8'h81;
        tick(); check_eq("post_fire", 32'(fire), 0);
        tick();
        tick(); check_eq("post_fire2", 32'(fire), 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
